// File: rtl/aes_op_sequencer.sv
// rtl/aes_op_sequencer.sv - control FSM sequencing one AES block operation between trackers and cipher core
module aes_op_sequencer #(
    parameter int NumRegsData = 4,
    parameter int ClearCycles = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   manual_op_i,
    input  logic                   start_i,
    input  logic                   key_clean_i,
    input  logic                   data_in_new_i,
    input  logic                   key_clear_i,
    input  logic                   data_in_clear_i,
    input  logic                   data_out_clear_i,
    input  logic [NumRegsData-1:0] data_out_re_i,
    output logic                   data_in_use_o,
    output logic                   data_in_arm_o,
    output logic                   core_in_valid_o,
    input  logic                   core_in_ready_i,
    input  logic                   core_out_valid_i,
    output logic                   core_out_ready_o,
    output logic                   data_out_we_o,
    output logic                   output_valid_o,
    output logic                   stall_o,
    output logic                   clear_o,
    output logic                   clear_key_o,
    output logic                   clear_data_in_o,
    output logic                   clear_data_out_o,
    output logic                   idle_o
);

    localparam int CntW = (ClearCycles > 1) ? $clog2(ClearCycles) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CORE_REQ  = 2'd1,
        CORE_WAIT = 2'd2,
        CLEAR     = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   pend_key_q, pend_key_d;
    logic                   pend_din_q, pend_din_d;
    logic                   pend_dout_q, pend_dout_d;
    logic                   sweep_key_q, sweep_key_d;
    logic                   sweep_din_q, sweep_din_d;
    logic                   sweep_dout_q, sweep_dout_d;
    logic                   output_valid_q, output_valid_d;
    logic [NumRegsData-1:0] mask_q, mask_d;

    logic clear_pending;
    logic out_free;
    logic start_cond;
    logic take_pending;
    logic [NumRegsData-1:0] mask_upd;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            pend_key_q     <= 1'b0;
            pend_din_q     <= 1'b0;
            pend_dout_q    <= 1'b0;
            sweep_key_q    <= 1'b0;
            sweep_din_q    <= 1'b0;
            sweep_dout_q   <= 1'b0;
            output_valid_q <= 1'b0;
            mask_q         <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pend_key_q     <= pend_key_d;
            pend_din_q     <= pend_din_d;
            pend_dout_q    <= pend_dout_d;
            sweep_key_q    <= sweep_key_d;
            sweep_din_q    <= sweep_din_d;
            sweep_dout_q   <= sweep_dout_d;
            output_valid_q <= output_valid_d;
            mask_q         <= mask_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        sweep_key_d      = sweep_key_q;
        sweep_din_d      = sweep_din_q;
        sweep_dout_d     = sweep_dout_q;
        take_pending     = 1'b0;
        data_in_use_o    = 1'b0;
        data_in_arm_o    = 1'b0;
        core_in_valid_o  = 1'b0;
        core_out_ready_o = 1'b0;
        data_out_we_o    = 1'b0;
        stall_o          = 1'b0;
        clear_o          = 1'b0;
        clear_key_o      = 1'b0;
        clear_data_in_o  = 1'b0;
        clear_data_out_o = 1'b0;

        clear_pending = pend_key_q | pend_din_q | pend_dout_q;
        out_free      = manual_op_i | ~output_valid_q;
        start_cond    = key_clean_i & (manual_op_i ? start_i : data_in_new_i) & ~rst_i;

        unique case (state_q)
            IDLE: begin
                if (clear_pending) begin
                    // The sweep owns the flags it services; new triggers re-pend.
                    state_d      = CLEAR;
                    cnt_d        = CntW'(ClearCycles - 1);
                    sweep_key_d  = pend_key_q;
                    sweep_din_d  = pend_din_q;
                    sweep_dout_d = pend_dout_q;
                    take_pending = 1'b1;
                end else if (start_cond) begin
                    data_in_use_o = 1'b1;
                    data_in_arm_o = 1'b1;
                    state_d       = CORE_REQ;
                end
            end
            CORE_REQ: begin
                core_in_valid_o = 1'b1;
                if (core_in_ready_i) begin
                    state_d = CORE_WAIT;
                end
            end
            CORE_WAIT: begin
                core_out_ready_o = out_free;
                if (core_out_valid_i) begin
                    if (out_free) begin
                        data_out_we_o = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        stall_o = 1'b1;
                    end
                end
            end
            CLEAR: begin
                clear_o          = 1'b1;
                clear_key_o      = sweep_key_q;
                clear_data_in_o  = sweep_din_q;
                clear_data_out_o = sweep_dout_q;
                if (cnt_q == '0) begin
                    state_d      = IDLE;
                    sweep_key_d  = 1'b0;
                    sweep_din_d  = 1'b0;
                    sweep_dout_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        pend_key_d  = (pend_key_q  & ~take_pending) | key_clear_i;
        pend_din_d  = (pend_din_q  & ~take_pending) | data_in_clear_i;
        pend_dout_d = (pend_dout_q & ~take_pending) | data_out_clear_i;

        // Read mask counts a register once; the write of a new result and a clear override it.
        output_valid_d = output_valid_q;
        mask_d         = mask_q;
        mask_upd       = mask_q | data_out_re_i;
        if (output_valid_q) begin
            if (&mask_upd) begin
                output_valid_d = 1'b0;
                mask_d         = '0;
            end else begin
                mask_d = mask_upd;
            end
        end
        if (data_out_we_o) begin
            output_valid_d = 1'b1;
            mask_d         = '0;
        end
        if (data_out_clear_i) begin
            output_valid_d = 1'b0;
            mask_d         = '0;
        end
    end

    assign output_valid_o = output_valid_q;
    assign idle_o         = (state_q == IDLE) & ~clear_pending;

endmodule

// File: tb/tb_aes_op_sequencer.sv
// tb/tb_aes_op_sequencer.sv - directed table-driven bench for aes_op_sequencer
module tb_aes_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_i, manual_op_i, start_i, key_clean_i, data_in_new_i;
    logic       key_clear_i, data_in_clear_i, data_out_clear_i;
    logic [3:0] data_out_re_i;
    logic       data_in_use_o, data_in_arm_o, core_in_valid_o, core_in_ready_i;
    logic       core_out_valid_i, core_out_ready_o, data_out_we_o, output_valid_o;
    logic       stall_o, clear_o, clear_key_o, clear_data_in_o, clear_data_out_o, idle_o;

    always #5 clk = ~clk;

    localparam logic [13:0] RST = 14'h2000, MAN = 14'h1000, STA = 14'h0800, KC = 14'h0400;
    localparam logic [13:0] DN = 14'h0200, KCL = 14'h0100, DICL = 14'h0080, DOCL = 14'h0040;
    localparam logic [13:0] CIR = 14'h0020, COV = 14'h0010;
    localparam logic [13:0] RE0 = 14'h0001, RE1 = 14'h0002, RE2 = 14'h0004, RE3 = 14'h0008;
    localparam logic [13:0] NONE = 14'h0000;

    localparam logic [11:0] USE = 12'h800, ARM = 12'h400, CIV = 12'h200, COR = 12'h100;
    localparam logic [11:0] WE = 12'h080, OV = 12'h040, STL = 12'h020, CLR = 12'h010;
    localparam logic [11:0] CK = 12'h008, CDI = 12'h004, CDO = 12'h002, IDL = 12'h001;
    localparam logic [11:0] ZERO = 12'h000;

    logic [13:0] in_v;
    logic [11:0] out_v;

    assign {rst_i, manual_op_i, start_i, key_clean_i, data_in_new_i, key_clear_i,
            data_in_clear_i, data_out_clear_i, core_in_ready_i, core_out_valid_i,
            data_out_re_i} = in_v;
    assign out_v = {data_in_use_o, data_in_arm_o, core_in_valid_o, core_out_ready_o,
                    data_out_we_o, output_valid_o, stall_o, clear_o, clear_key_o,
                    clear_data_in_o, clear_data_out_o, idle_o};

    aes_op_sequencer #(.NumRegsData(4), .ClearCycles(2)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .manual_op_i      (manual_op_i),
        .start_i          (start_i),
        .key_clean_i      (key_clean_i),
        .data_in_new_i    (data_in_new_i),
        .key_clear_i      (key_clear_i),
        .data_in_clear_i  (data_in_clear_i),
        .data_out_clear_i (data_out_clear_i),
        .data_out_re_i    (data_out_re_i),
        .data_in_use_o    (data_in_use_o),
        .data_in_arm_o    (data_in_arm_o),
        .core_in_valid_o  (core_in_valid_o),
        .core_in_ready_i  (core_in_ready_i),
        .core_out_valid_i (core_out_valid_i),
        .core_out_ready_o (core_out_ready_o),
        .data_out_we_o    (data_out_we_o),
        .output_valid_o   (output_valid_o),
        .stall_o          (stall_o),
        .clear_o          (clear_o),
        .clear_key_o      (clear_key_o),
        .clear_data_in_o  (clear_data_in_o),
        .clear_data_out_o (clear_data_out_o),
        .idle_o           (idle_o)
    );

    typedef struct {
        string       name;
        logic [13:0] stim;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic void add(input string n, input logic [13:0] s, input logic [11:0] e);
        vec_t v;
        v.name = n;
        v.stim = s;
        v.exp  = e;
        vecs.push_back(v);
    endfunction

    task automatic check(input string n, input logic [11:0] act, input logic [11:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: outputs got %b expected %b (use arm civ cor we ov stall clr ck cdi cdo idle)",
                      n, act, exp);
    endtask

    task automatic check_bit(input string n, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", n, act, exp);
    endtask

    int clr_cycles;
    int idle_seen;
    int stall_seen;
    int we_seen;

    initial begin
        // reset
        add("rst",          RST,                 IDL);
        // automatic start, core ready delayed
        add("auto_start",   KC | DN,             USE | ARM | IDL);
        add("auto_req1",    KC,                  CIV);
        add("auto_req2",    NONE,                CIV);
        add("auto_req3",    CIR,                 CIV);
        add("auto_wait",    NONE,                COR);
        add("auto_done",    COV,                 COR | WE);
        add("auto_idle",    NONE,                OV | IDL);
        // overwrite protection
        add("ow_start",     KC | DN,             USE | ARM | OV | IDL);
        add("ow_req",       CIR,                 CIV | OV);
        add("ow_wait",      NONE,                OV);
        add("ow_stall",     COV,                 OV | STL);
        add("ow_rd0",       COV | RE0,           OV | STL);
        add("ow_rd0_again", COV | RE0,           OV | STL);
        add("ow_rd1",       COV | RE1,           OV | STL);
        add("ow_rd2",       COV | RE2,           OV | STL);
        add("ow_rd3",       COV | RE3,           OV | STL);
        add("ow_release",   COV,                 COR | WE);
        add("ow_idle",      NONE,                OV | IDL);
        // manual mode
        add("man_nostart1", MAN | KC | DN,       OV | IDL);
        add("man_nostart2", MAN | KC | DN,       OV | IDL);
        add("man_start",    MAN | KC | STA,      USE | ARM | OV | IDL);
        add("man_req",      MAN | CIR,           CIV | OV);
        add("man_overwr",   MAN | COV,           COR | WE | OV);
        add("man_idle",     MAN,                 OV | IDL);
        add("auto_sta_ign", KC | STA,            OV | IDL);
        // clear sweep from IDLE
        add("clr_trig",     KCL | DOCL,          OV | IDL);
        add("clr_pend",     KC | DN,             ZERO);
        add("clr_sweep1",   NONE,                CLR | CK | CDO);
        add("clr_sweep2",   NONE,                CLR | CK | CDO);
        add("clr_idle",     NONE,                IDL);
        // clear during op, then trigger during sweep
        add("cop_start",    KC | DN,             USE | ARM | IDL);
        add("cop_req",      CIR,                 CIV);
        add("cop_wait_clr", DICL,                COR);
        add("cop_done",     COV,                 COR | WE);
        add("cop_sta_ign",  MAN | KC | STA,      OV);
        add("cop_sweep1",   KCL,                 OV | CLR | CDI);
        add("cop_sweep2",   NONE,                OV | CLR | CDI);
        add("cop_pend2",    NONE,                OV);
        add("cop_sweep3",   NONE,                OV | CLR | CK);
        add("cop_sweep4",   NONE,                OV | CLR | CK);
        add("cop_idle",     NONE,                OV | IDL);
        // reset mid-op
        add("rmo_start",    KC | DN,             USE | ARM | OV | IDL);
        add("rmo_req",      KCL,                 CIV | OV);
        add("rmo_rst",      RST,                 CIV | OV);
        add("rmo_after",    NONE,                IDL);
        add("rmo_restart",  KC | DN,             USE | ARM | IDL);
        add("rmo_rst2",     RST,                 CIV);

        in_v = RST;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            in_v = vecs[i].stim;
            #2;
            check(vecs[i].name, out_v, vecs[i].exp);
        end

        // clear_o lasts exactly ClearCycles cycles for a single trigger
        @(negedge clk);
        in_v = KCL;
        @(negedge clk);
        in_v = NONE;
        clr_cycles = 0;
        for (int k = 0; k < 8; k++) begin
            #2;
            if (clear_o) clr_cycles++;
            @(negedge clk);
        end
        #2;
        idle_seen = int'(idle_o);
        check_bit("seq_clear_len", clr_cycles, 2);
        check_bit("seq_clear_idle", idle_seen, 1);

        // data_out_clear releases a stalled result
        @(negedge clk);
        in_v = KC | DN | CIR | COV;
        stall_seen = 0;
        for (int k = 0; k < 6; k++) begin
            #2;
            if (stall_o) stall_seen = 1;
            @(negedge clk);
        end
        check_bit("seq_stall_seen", stall_seen, 1);
        in_v = DOCL | CIR | COV;
        #2;
        check_bit("seq_stall_at_clr", int'(stall_o), 1);
        @(negedge clk);
        in_v = CIR | COV;
        we_seen = 0;
        for (int k = 0; k < 3; k++) begin
            #2;
            if (data_out_we_o) we_seen = 1;
            @(negedge clk);
        end
        check_bit("seq_clr_release_we", we_seen, 1);

        in_v = RST;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aes_op_sequencer.md
Name: aes_op_sequencer

Overview:
- Control FSM that sequences one AES block operation between the register-status trackers and the cipher core.
- Decides when input data and key are usable and issues the use/arm pulses back to the trackers.
- Performs the valid/ready handshake with the cipher core.
- Tracks software reads of the output registers so an unread result is never overwritten in automatic mode, and runs timed clear sweeps.

Parameters:
- NumRegsData, 4, number of 32-bit data-output registers whose reads are tracked.
- ClearCycles, 2, cycles `clear_o` stays asserted per clear sweep (≥1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- manual_op_i  in  1  1: start only on `start_i`, output overwrite allowed; 0: automatic
- start_i  in  1  single-cycle start trigger (manual mode only)
- key_clean_i  in  1  key tracker reports clean key
- data_in_new_i  in  1  data-in tracker reports complete new data
- key_clear_i, data_in_clear_i, data_out_clear_i  in  1 each  clear triggers
- data_out_re_i  in  NumRegsData  per-register software read strobes
- data_in_use_o  out  1  pulse to data-in tracker `use` input
- data_in_arm_o  out  1  pulse arming data-in tracker
- core_in_valid_o  out  1  start request to cipher core
- core_in_ready_i  in  1  core accepts request
- core_out_valid_i  in  1  core result available
- core_out_ready_o  out  1  sequencer accepts result
- data_out_we_o  out  1  pulse writing output registers
- output_valid_o  out  1  unread result present
- stall_o  out  1  result held because output not yet read
- clear_o  out  1  clear sweep active
- clear_key_o, clear_data_in_o, clear_data_out_o  out  1 each  which targets the current sweep covers
- idle_o  out  1  FSM in IDLE with no pending clear

Behaviour:
- States: IDLE, CORE_REQ, CORE_WAIT, CLEAR. Reset (rst_i sampled high) returns to IDLE from any state.
- Reset values: all outputs 0 except `idle_o` = 1. Pending-clear flags, read mask and output_valid are also cleared by reset.
- Clear triggers arriving in any state OR into three pending flags. All triggers in one cycle merge into one sweep.
- IDLE, clear pending: go to CLEAR. Clear has priority over start.
- IDLE, start condition: start condition = `key_clean_i` & (manual ? `start_i` : `data_in_new_i`). When met:
  - pulse `data_in_use_o` and `data_in_arm_o` for one cycle;
  - go to CORE_REQ next cycle.
- `start_i` in automatic mode, or while not in IDLE: ignored, not remembered.
- CORE_REQ: `core_in_valid_o` = 1 until the cycle `core_in_ready_i` = 1, then CORE_WAIT. Valid must not drop before ready.
- CORE_WAIT:
  - out_free = manual_op_i | ~output_valid_q.
  - `core_out_ready_o` = out_free.
  - On `core_out_valid_i` & out_free: pulse `data_out_we_o`, set output_valid_q, zero the read mask, go to IDLE.
  - On `core_out_valid_i` & ~out_free: `stall_o` = 1, stay in CORE_WAIT.
- Read tracking:
  - read_mask |= `data_out_re_i` each cycle while output_valid_q.
  - When the mask becomes all-ones (including the re bits of the current cycle), clear output_valid_q and the mask on the next edge.
  - A `data_out_we_o` in the same cycle wins: valid stays 1, mask resets.
- `data_out_clear_i` zeroes output_valid_q and the mask immediately (next edge) in any state. This releases a stall.
- CLEAR:
  - Load a counter with ClearCycles−1 on entry.
  - `clear_o` = 1 and the target outputs reflect the latched flags for exactly ClearCycles cycles.
  - At count 0, clear the flags serviced in this sweep and return to IDLE.
  - Triggers arriving during a sweep stay pending for a following sweep.
- Clear triggers during CORE_REQ/CORE_WAIT do not abort the operation; they are serviced on return to IDLE.
- `idle_o` = (state==IDLE) & no pending clear.

Test Plan:
- Automatic start: `key_clean_i`=1, `data_in_new_i`=1, manual=0 → `data_in_use_o` and `data_in_arm_o` pulse one cycle. `core_in_valid_o` is high the next cycle and held until `core_in_ready_i` (delay core ready 3 cycles: valid stays 1 for 3 cycles).
- Overwrite protection: first result written, no reads, second op completes → `stall_o`=1 and `core_out_ready_o`=0. Read regs 0..3 one per cycle → after the 4th read, `output_valid_o` drops, the next cycle `data_out_we_o` pulses and `stall_o`=0.
- Manual mode: manual=1, `data_in_new_i`=1 without `start_i` → stays IDLE. `start_i` pulse → op runs. Unread output is overwritten without stall.
- Clear: `key_clear_i` and `data_out_clear_i` in the same cycle from IDLE, ClearCycles=2 → `clear_o`=1 for exactly 2 cycles, `clear_key_o`=`clear_data_out_o`=1, `clear_data_in_o`=0, `output_valid_o`=0, then `idle_o`=1.
- Clear during op: `data_in_clear_i` in CORE_WAIT → op completes normally, then a CLEAR sweep of 2 cycles. A `start_i` in the cycle the FSM returns to IDLE is ignored.
- Reset mid-op: assert `rst_i` in CORE_REQ → next cycle all outputs 0, `idle_o`=1, pending clears and output_valid gone.
